oc8051_code_loader: RTL

//  Writer side of the 8051 program store: receives framed code images as a byte stream
//  (from a UART receiver or debug link) and writes them into writable code memory.

---
 rtl/oc8051_loader_pkg.sv | 29 ++
 rtl/oc8051_loader_timer.sv | 29 ++
 rtl/oc8051_code_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/oc8051_loader_pkg.sv
// Shared definitions for the 8051 code loader: FSM states, framing byte and error codes.
// Build option OC8051_LOADER_CHKSUM_EN (in the top) enables the trailing CHK byte.
package oc8051_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_FIN
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CHK   = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  localparam int unsigned TMO_W = 16;

  // A LEN byte of zero stands for a full 256-byte payload.
  function automatic logic [8:0] len_to_count(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/oc8051_loader_timer.sv
// Idle-cycle counter for the code loader: expires after LIMIT enabled cycles without a clear.
module oc8051_loader_timer
  import oc8051_loader_pkg::*;
#(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TMO_W-1:0] r_cnt;
  logic             w_hit;

  // r_cnt holds (idle cycles so far - 1) during the current idle cycle.
  assign w_hit    = (r_cnt == TMO_W'(LIMIT - 1));
  assign o_expire = i_en & ~i_clr & w_hit;

  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_en || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/oc8051_code_loader.sv
// oc8051_code_loader: writes framed code images from a byte stream into code memory.
// Build option OC8051_LOADER_CHKSUM_EN adds a trailing CHK byte that must bring the frame sum to zero.
module oc8051_code_loader
  import oc8051_loader_pkg::*;
#(
  parameter int unsigned CODE_AW     = 7,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               mem_we,
  output logic [CODE_AW-1:0] mem_addr,
  output logic [7:0]         mem_wdata,
  output logic               cpu_hold,
  output logic               load_done,
  output logic               load_err,
  output logic [1:0]         err_code
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_cur;
  logic [8:0]         r_remain;
  logic               r_range;
  logic [1:0]         r_err_code;
  logic               r_tmo_pulse;
  logic               r_mem_we;
  logic [CODE_AW-1:0] r_mem_addr;
  logic [7:0]         r_mem_wdata;

  logic               w_accept;
  logic               w_expire;
  logic               w_timer_en;
  logic               w_in_range;
  logic               w_last_data;
  logic [1:0]         w_fin_err;

`ifdef OC8051_LOADER_CHKSUM_EN
  logic [7:0]         r_sum;
  logic [7:0]         w_sum_final;
`endif

  assign w_accept    = rx_valid & rx_ready;
  assign w_timer_en  = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign w_in_range  = ((r_cur >> CODE_AW) == 16'd0);
  assign w_last_data = (r_remain == 9'd1);

  // Error code latched on the byte that moves the frame into FIN.
`ifdef OC8051_LOADER_CHKSUM_EN
  assign w_sum_final = r_sum + rx_data;
  assign w_fin_err   = (w_sum_final != 8'h00) ? ERR_CHK :
                       (r_range ? ERR_RANGE : ERR_NONE);
`else
  assign w_fin_err   = (r_range || !w_in_range) ? ERR_RANGE : ERR_NONE;
`endif

  oc8051_loader_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  assign rx_ready  = (r_state != ST_FIN);
  assign cpu_hold  = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign load_done = (r_state == ST_FIN) && (r_err_code == ERR_NONE);
  assign load_err  = ((r_state == ST_FIN) && (r_err_code != ERR_NONE)) || r_tmo_pulse;
  assign err_code  = r_err_code;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && (rx_data == SYNC_BYTE)) w_state_nxt = ST_ADDR_H;
      ST_ADDR_H: if (w_accept) w_state_nxt = ST_ADDR_L;
      ST_ADDR_L: if (w_accept) w_state_nxt = ST_LEN;
      ST_LEN:    if (w_accept) w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (w_accept && w_last_data) begin
`ifdef OC8051_LOADER_CHKSUM_EN
          w_state_nxt = ST_CHK;
`else
          w_state_nxt = ST_FIN;
`endif
        end
      end
      ST_CHK:    if (w_accept) w_state_nxt = ST_FIN;
      ST_FIN:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (w_expire) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Timeout jumps straight to IDLE; its load_err pulse is registered so it
  // appears together with err_code=3.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur       <= '0;
      r_remain    <= '0;
      r_range     <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_tmo_pulse <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifdef OC8051_LOADER_CHKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_mem_we    <= 1'b0;
      r_tmo_pulse <= w_expire;
      if (w_expire) begin
        r_err_code <= ERR_TMO;
      end else if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              r_err_code <= ERR_NONE;
              r_range    <= 1'b0;
`ifdef OC8051_LOADER_CHKSUM_EN
              r_sum      <= '0;
`endif
            end
          end
          ST_ADDR_H: begin
            r_cur[15:8] <= rx_data;
`ifdef OC8051_LOADER_CHKSUM_EN
            r_sum       <= r_sum + rx_data;
`endif
          end
          ST_ADDR_L: begin
            r_cur[7:0] <= rx_data;
`ifdef OC8051_LOADER_CHKSUM_EN
            r_sum      <= r_sum + rx_data;
`endif
          end
          ST_LEN: begin
            r_remain <= len_to_count(rx_data);
`ifdef OC8051_LOADER_CHKSUM_EN
            r_sum    <= r_sum + rx_data;
`endif
          end
          ST_DATA: begin
            r_mem_we    <= w_in_range;
            r_mem_addr  <= r_cur[CODE_AW-1:0];
            r_mem_wdata <= rx_data;
            r_cur       <= r_cur + 16'd1;
            r_remain    <= r_remain - 9'd1;
            if (!w_in_range) begin
              r_range <= 1'b1;
            end
`ifdef OC8051_LOADER_CHKSUM_EN
            r_sum <= r_sum + rx_data;
`else
            if (w_last_data) begin
              r_err_code <= w_fin_err;
            end
`endif
          end
          ST_CHK: begin
`ifdef OC8051_LOADER_CHKSUM_EN
            r_err_code <= w_fin_err;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
